forward_hazard_unit: RTL and testbench

Parametrised operand-forwarding and load-use hazard controller for the pipelined RV32I core. Sits beside the ID/EX boundary: for each source operand of the instruction in ID it picks the youngest in-flight producer among NUM_SRC later pipeline stages, and a small state machine stalls ID (inserting EX bubbles) while a load result is not yet available, including multi-cycle data-memory waits. Replaces the fixed two-stage, two-operand forwarding logic.

---
 rtl/forward_hazard_unit_pkg.sv | 24 ++
 rtl/forward_hazard_unit_match.sv | 36 +++
 rtl/forward_hazard_unit.sv | 103 ++++++++++
 tb/tb_forward_hazard_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// rtl/forward_hazard_unit_pkg.sv - shared types for the operand-forwarding / load-use hazard unit
package forward_hazard_unit_pkg;

    localparam int FWD_NUM_SRC_DEFAULT = 2;
    localparam int FWD_NUM_OPS_DEFAULT = 2;
    localparam int FWD_SEL_W_DEFAULT   = $clog2(FWD_NUM_SRC_DEFAULT + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LU_BUBBLE = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LU_BUBBLE = ST_LU_BUBBLE,
        MEM_WAIT  = ST_MEM_WAIT
    } hazard_state_t;

    typedef logic [FWD_SEL_W_DEFAULT-1:0] fwd_src_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/forward_hazard_unit_match.sv
// rtl/forward_hazard_unit_match.sv - per-operand producer match and youngest-first priority encoder
module forward_hazard_unit_match
    import forward_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC = FWD_NUM_SRC_DEFAULT,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC-1:0]      src_load_regfile,
    input  logic [NUM_SRC-1:0][4:0] src_rd,
    input  logic [4:0]              rs,
    input  logic                    rs_used,
    output logic [SEL_W-1:0]        sel
);

    logic [NUM_SRC-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            match[k] = src_valid[k] & src_load_regfile[k] & rs_used &
                       (src_rd[k] == rs) & (src_rd[k] != 5'd0);
        end
    end

    // Scan oldest to youngest so the lowest matching stage overwrites the rest.
    always_comb begin
        sel = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - operand forwarding select and load-use stall FSM
// Optional stall-cycle performance counter enabled by FWD_PERF_CNT_EN.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC = FWD_NUM_SRC_DEFAULT,
    parameter int NUM_OPS = FWD_NUM_OPS_DEFAULT,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipe_stall,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC-1:0]           src_load_regfile,
    input  logic [NUM_SRC-1:0]           src_is_load,
    input  logic [NUM_SRC-1:0][4:0]      src_rd,
    input  logic                         dmem_resp,
    input  logic [NUM_OPS-1:0][4:0]      id_rs,
    input  logic [NUM_OPS-1:0]           id_rs_used,
    output logic [NUM_OPS-1:0][SEL_W-1:0] fwd_sel,
    output logic                         stall_id,
    output logic                         bubble_ex,
    output logic [31:0]                  stall_cycles
);

    hazard_state_t state;
    hazard_state_t state_next;
    logic          load_use;
    logic          unused_is_load;

    for (genvar j = 0; j < NUM_OPS; j++) begin : g_op
        forward_hazard_unit_match #(
            .NUM_SRC (NUM_SRC),
            .SEL_W   (SEL_W)
        ) u_match (
            .src_valid        (src_valid),
            .src_load_regfile (src_load_regfile),
            .src_rd           (src_rd),
            .rs               (id_rs[j]),
            .rs_used          (id_rs_used[j]),
            .sel              (fwd_sel[j])
        );
    end

    // Only the youngest stage can hold a load whose data is not yet forwardable.
    assign unused_is_load = ^src_is_load;

    always_comb begin
        load_use = 1'b0;
        for (int j = 0; j < NUM_OPS; j++) begin
            if (fwd_sel[j] == SEL_W'(1)) begin
                load_use = load_use | src_is_load[0];
            end
        end
    end

    always_comb begin
        stall_id   = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (load_use) begin
                    stall_id   = 1'b1;
                    state_next = LU_BUBBLE;
                end
            end
            LU_BUBBLE, MEM_WAIT: begin
                if (dmem_resp) begin
                    state_next = IDLE;
                end else begin
                    stall_id   = 1'b1;
                    state_next = MEM_WAIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bubble_ex = stall_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (!pipe_stall) begin
            state <= state_next;
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (!pipe_stall && stall_id) begin
            stall_cycles <= sat_inc32(stall_cycles);
        end
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - self-checking bench for forward_hazard_unit
module tb_forward_hazard_unit;

    localparam int NS = 2;
    localparam int NO = 2;
    localparam int SW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pipe_stall;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0]        src_load_regfile;
    logic [NS-1:0]        src_is_load;
    logic [NS-1:0][4:0]   src_rd;
    logic                 dmem_resp;
    logic [NO-1:0][4:0]   id_rs;
    logic [NO-1:0]        id_rs_used;
    logic [NO-1:0][SW-1:0] fwd_sel;
    logic                 stall_id;
    logic                 bubble_ex;
    logic [31:0]          stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    forward_hazard_unit #(.NUM_SRC(NS), .NUM_OPS(NO), .SEL_W(SW)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_stall       (pipe_stall),
        .src_valid        (src_valid),
        .src_load_regfile (src_load_regfile),
        .src_is_load      (src_is_load),
        .src_rd           (src_rd),
        .dmem_resp        (dmem_resp),
        .id_rs            (id_rs),
        .id_rs_used       (id_rs_used),
        .fwd_sel          (fwd_sel),
        .stall_id         (stall_id),
        .bubble_ex        (bubble_ex),
        .stall_cycles     (stall_cycles)
    );

    typedef struct {
        string      name;
        logic [1:0] v, w, l;
        logic [4:0] rd0, rd1, rs0, rs1;
        logic [1:0] used;
        logic [1:0] e_sel0, e_sel1;
        logic       e_stall;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef FWD_PERF_CNT_EN
        return n;
`else
        return (n == n) ? 32'd0 : 32'd1;
`endif
    endfunction

    task automatic clear_in();
        src_valid = '0; src_load_regfile = '0; src_is_load = '0; src_rd = '0;
        id_rs = '0; id_rs_used = '0; dmem_resp = 1'b0; pipe_stall = 1'b0;
    endtask

    task automatic set_stage(input int k, input logic ld, input logic [4:0] rd);
        src_valid[k] = 1'b1; src_load_regfile[k] = 1'b1;
        src_is_load[k] = ld; src_rd[k] = rd;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Load x3 in stage 0 consumed by rs1: drives the IDLE hazard cycle.
    task automatic load_hazard();
        clear_in();
        set_stage(0, 1'b1, 5'd3);
        id_rs[0] = 5'd3; id_rs_used = 2'b01;
    endtask

    // Load now in stage 1 with a bubble ahead of it.
    task automatic load_in_s1(input logic resp);
        clear_in();
        set_stage(1, 1'b1, 5'd3);
        id_rs[0] = 5'd3; id_rs_used = 2'b01; dmem_resp = resp;
    endtask

    // Reference: producer search plus a pending-load phase (0 none, 1 bubble issued, 2 waiting).
    int          m_phase;
    logic [31:0] m_cnt;

    function automatic logic [SW-1:0] ref_sel(input int j);
        for (int k = 0; k < NS; k++) begin
            if (src_valid[k] && src_load_regfile[k] && id_rs_used[j] &&
                src_rd[k] != 0 && src_rd[k] == id_rs[j])
                return SW'(k + 1);
        end
        return '0;
    endfunction

    initial begin
        tbl[0] = '{"alu_x5_rs1",    2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 5'd5, 5'd0, 2'b01, 2'd1, 2'd0, 1'b0};
        tbl[1] = '{"youngest_x7",   2'b11, 2'b11, 2'b00, 5'd7, 5'd7, 5'd0, 5'd7, 2'b10, 2'd0, 2'd1, 1'b0};
        tbl[2] = '{"x0_never",      2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 2'd0, 2'd0, 1'b0};
        tbl[3] = '{"stage1_both",   2'b10, 2'b10, 2'b00, 5'd0, 5'd9, 5'd9, 5'd9, 2'b11, 2'd2, 2'd2, 1'b0};
        tbl[4] = '{"rs_unused",     2'b01, 2'b01, 2'b00, 5'd4, 5'd0, 5'd4, 5'd4, 2'b00, 2'd0, 2'd0, 1'b0};
        tbl[5] = '{"src_invalid",   2'b00, 2'b01, 2'b00, 5'd4, 5'd0, 5'd4, 5'd0, 2'b01, 2'd0, 2'd0, 1'b0};
        tbl[6] = '{"no_rf_write",   2'b01, 2'b00, 2'b00, 5'd4, 5'd0, 5'd4, 5'd0, 2'b01, 2'd0, 2'd0, 1'b0};
        tbl[7] = '{"load_both_ops", 2'b01, 2'b01, 2'b01, 5'd3, 5'd0, 5'd3, 5'd3, 2'b11, 2'd1, 2'd1, 1'b1};
        tbl[8] = '{"load_in_s1",    2'b10, 2'b10, 2'b10, 5'd0, 5'd3, 5'd3, 5'd0, 2'b01, 2'd2, 2'd0, 1'b0};
        tbl[9] = '{"load_rs2_only", 2'b11, 2'b11, 2'b01, 5'd6, 5'd8, 5'd8, 5'd6, 2'b11, 2'd2, 2'd1, 1'b1};

        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_stall", {31'd0, stall_id}, 32'd0);
        chk("rst_bubble", {31'd0, bubble_ex}, 32'd0);
        chk("rst_sel", {28'd0, fwd_sel}, 32'd0);
        chk("rst_cnt", stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational table, frozen so the FSM stays in IDLE throughout.
        for (int i = 0; i < 10; i++) begin
            clear_in();
            pipe_stall = 1'b1;
            src_valid = tbl[i].v; src_load_regfile = tbl[i].w; src_is_load = tbl[i].l;
            src_rd[0] = tbl[i].rd0; src_rd[1] = tbl[i].rd1;
            id_rs[0] = tbl[i].rs0; id_rs[1] = tbl[i].rs1; id_rs_used = tbl[i].used;
            #1;
            chk({tbl[i].name, "_sel0"}, {30'd0, fwd_sel[0]}, {30'd0, tbl[i].e_sel0});
            chk({tbl[i].name, "_sel1"}, {30'd0, fwd_sel[1]}, {30'd0, tbl[i].e_sel1});
            chk({tbl[i].name, "_stall"}, {31'd0, stall_id}, {31'd0, tbl[i].e_stall});
            chk({tbl[i].name, "_bubble"}, {31'd0, bubble_ex}, {31'd0, tbl[i].e_stall});
            @(negedge clk);
        end
        clear_in();
        #1;
        chk("frozen_idle_stall", {31'd0, stall_id}, 32'd0);
        chk("frozen_cnt", stall_cycles, 32'd0);
        @(negedge clk);

        // Load-use with immediate response: one stall cycle.
        do_reset();
        load_hazard(); #1;
        chk("lu1_stall", {31'd0, stall_id}, 32'd1);
        chk("lu1_bubble", {31'd0, bubble_ex}, 32'd1);
        @(negedge clk);
        load_in_s1(1'b1); #1;
        chk("lu1_resp_stall", {31'd0, stall_id}, 32'd0);
        chk("lu1_resp_sel", {30'd0, fwd_sel[0]}, 32'd2);
        @(negedge clk);
        clear_in(); dmem_resp = 1'b1; #1;
        chk("lu1_idle_resp_ignored", {31'd0, stall_id}, 32'd0);
        chk("lu1_cnt", stall_cycles, cnt_exp(32'd1));
        @(negedge clk);

        // Response low for three cycles: four stall cycles total.
        do_reset();
        load_hazard(); #1;
        chk("lu4_a", {31'd0, stall_id}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            load_in_s1(1'b0); #1;
            chk("lu4_wait_stall", {31'd0, stall_id}, 32'd1);
            chk("lu4_wait_bubble", {31'd0, bubble_ex}, 32'd1);
        end
        @(negedge clk);
        load_in_s1(1'b1); #1;
        chk("lu4_done_stall", {31'd0, stall_id}, 32'd0);
        chk("lu4_done_sel", {30'd0, fwd_sel[0]}, 32'd2);
        chk("lu4_cnt", stall_cycles, cnt_exp(32'd4));
        @(negedge clk);
        clear_in(); #1;
        chk("lu4_back_idle", {31'd0, stall_id}, 32'd0);
        @(negedge clk);

        // Freeze while in MEM_WAIT.
        do_reset();
        load_hazard(); @(negedge clk);
        load_in_s1(1'b0); @(negedge clk);
        load_in_s1(1'b0); #1;
        chk("frz_w1_cnt", stall_cycles, cnt_exp(32'd2));
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            load_in_s1(1'b0); pipe_stall = 1'b1; #1;
            chk("frz_stall", {31'd0, stall_id}, 32'd1);
            chk("frz_cnt", stall_cycles, cnt_exp(32'd3));
            @(negedge clk);
        end
        load_in_s1(1'b0); #1;
        chk("frz_after_stall", {31'd0, stall_id}, 32'd1);
        chk("frz_after_cnt", stall_cycles, cnt_exp(32'd3));
        @(negedge clk);
        load_in_s1(1'b1); #1;
        chk("frz_done_stall", {31'd0, stall_id}, 32'd0);
        chk("frz_done_cnt", stall_cycles, cnt_exp(32'd4));
        @(negedge clk);

        // Asynchronous reset in MEM_WAIT.
        do_reset();
        load_hazard(); @(negedge clk);
        load_in_s1(1'b0); @(negedge clk);
        load_in_s1(1'b0); #1;
        chk("rstw_pre_stall", {31'd0, stall_id}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_stall", {31'd0, stall_id}, 32'd0);
        chk("rstw_bubble", {31'd0, bubble_ex}, 32'd0);
        chk("rstw_cnt", stall_cycles, 32'd0);
        chk("rstw_sel", {30'd0, fwd_sel[0]}, 32'd2);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the reference.
        do_reset();
        m_phase = 0;
        m_cnt = 32'd0;
        for (int i = 0; i < 400; i++) begin
            logic exp_stall;
            logic hazard;
            logic [SW-1:0] es [NO];
            clear_in();
            for (int k = 0; k < NS; k++) begin
                src_valid[k] = ($urandom_range(0, 9) < 7);
                src_load_regfile[k] = ($urandom_range(0, 9) < 8);
                src_is_load[k] = ($urandom_range(0, 2) == 0);
                src_rd[k] = 5'($urandom_range(0, 7));
            end
            for (int j = 0; j < NO; j++) begin
                id_rs[j] = 5'($urandom_range(0, 7));
                id_rs_used[j] = ($urandom_range(0, 3) != 0);
            end
            dmem_resp = ($urandom_range(0, 2) == 0);
            pipe_stall = ($urandom_range(0, 7) == 0);
            hazard = 1'b0;
            for (int j = 0; j < NO; j++) begin
                es[j] = ref_sel(j);
                if (es[j] == SW'(1) && src_is_load[0]) hazard = 1'b1;
            end
            exp_stall = (m_phase == 0) ? hazard : !dmem_resp;
            #1;
            for (int j = 0; j < NO; j++)
                chk("rnd_sel", {30'd0, fwd_sel[j]}, {30'd0, es[j]});
            chk("rnd_stall", {31'd0, stall_id}, {31'd0, exp_stall});
            chk("rnd_bubble", {31'd0, bubble_ex}, {31'd0, exp_stall});
            chk("rnd_cnt", stall_cycles, cnt_exp(m_cnt));
            if (!pipe_stall) begin
                if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_phase == 0) m_phase = hazard ? 1 : 0;
                else m_phase = dmem_resp ? 0 : 2;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
